pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning): DRAIN_CYCLES, 3, cycles to empty ID..WB after a halt is accepted; CNT_W, 16, width of the performance counters.
REQ-002 CLK  in  1  single clock; all state on rising edge.
REQ-003 nRST  in  1  asynchronous, active-low reset.
REQ-004 id_instr  in  WORD_W  instruction held in IF/ID; rs = [25:21], rt = [20:16].
REQ-005 id_uses_rt  in  1  ID instruction reads rt.
REQ-006 id_halt  in  1  decoded halt in ID.
REQ-007 ex_memRead, ex_RegWrite  in  1 each  EX-stage control.
REQ-008 ex_rd  in  REG_AW  EX-stage destination register.
REQ-009 ex_redirect  in  1  branch taken or jump/jal resolved in EX.
REQ-010 imem_ready, dmem_req, dmem_ready  in  1 each  memory handshake.
REQ-011 pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  pipeline register enables.
REQ-012 if_id_flush, id_ex_flush  out  1 each  insert bubble on next edge.
REQ-013 halt_out  out  1  processor halted.
REQ-014 stall_cnt, flush_cnt  out  CNT_W each  saturating performance counters.

Function
REQ-015 FSM states SHALL be RUN, DRAIN, HALTED.
REQ-016 freeze = dmem_req && !dmem_ready; while freeze, all five enables SHALL be 0 and both flushes 0, in RUN and in DRAIN.
REQ-017 In RUN without freeze, ex_redirect SHALL give pc_en=1, all other enables 1, if_id_flush=1, id_ex_flush=1.
REQ-018 Load-use = ex_memRead && ex_RegWrite && ex_rd!=0 && (ex_rd==rs || (id_uses_rt && ex_rd==rt)); absent redirect it SHALL give pc_en=0, if_id_en=0, id_ex_flush=1, others enabled.
REQ-019 ex_redirect SHALL take priority over load-use and halt in the same cycle.
REQ-020 !imem_ready (no freeze, redirect or load-use) SHALL give pc_en=0, if_id_flush=1, downstream enabled.
REQ-021 id_halt in RUN with no freeze, redirect or load-use SHALL give pc_en=0, if_id_en=0, id_ex_en=1 and move to DRAIN with counter=DRAIN_CYCLES on the next edge.
REQ-022 In DRAIN: pc_en=0, if_id_flush=1, downstream enabled; counter decrements on each non-freeze cycle; at counter==1 with no freeze, next state HALTED.
REQ-023 In HALTED: all enables 0, flushes 0, halt_out=1; only reset leaves HALTED.
REQ-024 halt_out SHALL be a registered function of state (1 only in HALTED).
REQ-025 stall_cnt SHALL increment on every cycle with freeze or load-use in RUN; flush_cnt on every cycle with ex_redirect in RUN without freeze; both saturate at all-ones, never wrap.
REQ-026 Counters SHALL not change in HALTED.

Reset
REQ-027 nRST low SHALL force state RUN, drain counter 0, stall_cnt=0, flush_cnt=0, halt_out=0 immediately, independent of CLK.
REQ-028 During reset, enables SHALL follow RUN combinational rules; reset asserted mid-DRAIN or in HALTED returns to RUN.

Structure
REQ-029 WORD_W, REG_AW and enum hzd_state_t {RUN, DRAIN, HALTED} SHALL live in common_types.
REQ-030 One sub-module sat_counter (parameter CNT_W, inputs inc, outputs count) SHALL be instantiated twice.
REQ-031 Enable/flush outputs SHALL be combinational from inputs and state; no output latches.

Verification
REQ-032 ex_memRead=1, ex_RegWrite=1, ex_rd=8, id_instr rs=8 -> pc_en=0, if_id_en=0, id_ex_flush=1, stall_cnt +1.
REQ-033 Same as REQ-032 plus ex_redirect=1 -> pc_en=1, both flushes 1, flush_cnt +1, stall_cnt unchanged.
REQ-034 ex_rd=0 with matching rs=0, ex_memRead=1 -> no stall, all enables 1.
REQ-035 id_halt=1 in RUN, DRAIN_CYCLES=3, dmem_req=1/dmem_ready=0 for 2 cycles during DRAIN -> HALTED after 5 cycles, halt_out=1, enables 0.
REQ-036 Force 70000 freeze cycles with CNT_W=16 -> stall_cnt holds at 65535.
REQ-037 nRST pulsed low in HALTED, between edges -> halt_out=0, counters 0 before next CLK edge, state RUN.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: datapath widths,
// controller state encoding and instruction field extractors.
package common_types;

   localparam int WORD_W = 32;
   localparam int REG_AW = 5;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } hzd_state_t;

   // Source register fields of an R/I-format instruction.
   function automatic logic [REG_AW-1:0] rs_of(input logic [WORD_W-1:0] instr);
      return instr[25:21];
   endfunction

   function automatic logic [REG_AW-1:0] rt_of(input logic [WORD_W-1:0] instr);
      return instr[20:16];
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side signals seen by the hazard controller: ID/EX decode
// information and memory handshakes in, register enables and bubble
// requests out.
interface pipe_hazard_ctrl_if;
   import common_types::*;

   logic [WORD_W-1:0] id_instr;
   logic              id_uses_rt;
   logic              id_halt;
   logic              ex_memRead;
   logic              ex_RegWrite;
   logic [REG_AW-1:0] ex_rd;
   logic              ex_redirect;
   logic              imem_ready;
   logic              dmem_req;
   logic              dmem_ready;

   logic              pc_en;
   logic              if_id_en;
   logic              id_ex_en;
   logic              ex_mem_en;
   logic              mem_wb_en;
   logic              if_id_flush;
   logic              id_ex_flush;

   // The pipeline datapath drives decode/handshake information.
   modport master (
      output id_instr, id_uses_rt, id_halt, ex_memRead, ex_RegWrite, ex_rd,
             ex_redirect, imem_ready, dmem_req, dmem_ready,
      input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
             if_id_flush, id_ex_flush
   );

   // The hazard controller consumes it and steers the pipeline registers.
   modport slave (
      input  id_instr, id_uses_rt, id_halt, ex_memRead, ex_RegWrite, ex_rd,
             ex_redirect, imem_ready, dmem_req, dmem_ready,
      output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
             if_id_flush, id_ex_flush
   );

endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the stall/flush performance counters.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   // Count qualifying cycles, sticking at all-ones instead of wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking (<=) so every flop samples
      // pre-edge values regardless of block ordering.
      if (!rst_n) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall controller for a 5-stage pipeline: handles memory freezes,
// EX redirects, load-use interlocks, I-fetch wait and the halt drain
// sequence, and keeps saturating stall/flush performance counters.
module pipe_hazard_ctrl
   import common_types::*;
#(
   parameter int DRAIN_CYCLES = 3,
   parameter int CNT_W        = 16
) (
   input  logic                 CLK,
   input  logic                 nRST,
   pipe_hazard_ctrl_if.slave    hz,
   output logic                 halt_out,
   output logic [CNT_W-1:0]     stall_cnt,
   output logic [CNT_W-1:0]     flush_cnt
);

   localparam int DW = $clog2(DRAIN_CYCLES + 1);

   hzd_state_t        state_q, state_d;
   logic [DW-1:0]     drain_q, drain_d;

   logic              freeze;
   logic              load_use;
   logic [REG_AW-1:0] id_rs, id_rt;
   logic              pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
   logic              if_id_flush, id_ex_flush;
   logic              stall_inc, flush_inc;
   logic              unused_instr_bits;

   assign id_rs = rs_of(hz.id_instr);
   assign id_rt = rt_of(hz.id_instr);
   assign unused_instr_bits = ^{hz.id_instr[WORD_W-1:26], hz.id_instr[15:0]};

   assign freeze   = hz.dmem_req && !hz.dmem_ready;
   // r0 is hardwired zero, so a load targeting it can never create a hazard.
   assign load_use = hz.ex_memRead && hz.ex_RegWrite && (hz.ex_rd != '0) &&
                     ((hz.ex_rd == id_rs) || (hz.id_uses_rt && (hz.ex_rd == id_rt)));

   // Next state, drain countdown and pipeline steering, by priority.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves a latch.
      state_d     = state_q;
      drain_d     = drain_q;
      pc_en       = 1'b1;
      if_id_en    = 1'b1;
      id_ex_en    = 1'b1;
      ex_mem_en   = 1'b1;
      mem_wb_en   = 1'b1;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;

      unique case (state_q)
         RUN: begin
            if (freeze) begin
               {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '0;
            end else if (hz.ex_redirect) begin
               if_id_flush = 1'b1;
               id_ex_flush = 1'b1;
            end else if (load_use) begin
               pc_en       = 1'b0;
               if_id_en    = 1'b0;
               id_ex_flush = 1'b1;
            end else if (hz.id_halt) begin
               // Halt moves on into EX; nothing new is fetched behind it.
               pc_en    = 1'b0;
               if_id_en = 1'b0;
               state_d  = DRAIN;
               drain_d  = DW'(DRAIN_CYCLES);
            end else if (!hz.imem_ready) begin
               pc_en       = 1'b0;
               if_id_flush = 1'b1;
            end
         end
         DRAIN: begin
            if (freeze) begin
               {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '0;
            end else begin
               pc_en       = 1'b0;
               if_id_flush = 1'b1;
               drain_d     = drain_q - DW'(1);
               if (drain_q == DW'(1)) begin
                  state_d = HALTED;
               end
            end
         end
         HALTED: begin
            {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '0;
         end
         default: begin
            state_d = RUN;
         end
      endcase
   end

   assign hz.pc_en       = pc_en;
   assign hz.if_id_en    = if_id_en;
   assign hz.id_ex_en    = id_ex_en;
   assign hz.ex_mem_en   = ex_mem_en;
   assign hz.mem_wb_en   = mem_wb_en;
   assign hz.if_id_flush = if_id_flush;
   assign hz.id_ex_flush = id_ex_flush;

   // State, drain counter and registered halt indication.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q  <= RUN;
         drain_q  <= '0;
         halt_out <= 1'b0;
      end else begin
         state_q  <= state_d;
         drain_q  <= drain_d;
         halt_out <= (state_d == HALTED);
      end
   end

   // A load-use cycle overridden by a redirect is not a stall.
   assign stall_inc = (state_q == RUN) && (freeze || (load_use && !hz.ex_redirect));
   assign flush_inc = (state_q == RUN) && hz.ex_redirect && !freeze;

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (CLK),
      .rst_n (nRST),
      .inc   (stall_inc),
      .count (stall_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk   (CLK),
      .rst_n (nRST),
      .inc   (flush_inc),
      .count (flush_cnt)
   );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: hazard priorities, halt drain
// with freeze, asynchronous reset out of HALTED and counter saturation.
module tb_pipe_hazard_ctrl;
   import common_types::*;

   localparam int CNT_W = 16;

   logic             CLK;
   logic             nRST;
   logic             halt_out;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   pipe_hazard_ctrl_if hz();

   pipe_hazard_ctrl #(.DRAIN_CYCLES(3), .CNT_W(CNT_W)) dut (
      .CLK       (CLK),
      .nRST      (nRST),
      .hz        (hz),
      .halt_out  (halt_out),
      .stall_cnt (stall_cnt),
      .flush_cnt (flush_cnt)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic set_instr(input logic [4:0] rs, input logic [4:0] rt);
      hz.id_instr = {6'd0, rs, rt, 16'd0};
   endtask

   initial begin
      hz.id_instr    = '0;
      hz.id_uses_rt  = 1'b0;
      hz.id_halt     = 1'b0;
      hz.ex_memRead  = 1'b0;
      hz.ex_RegWrite = 1'b0;
      hz.ex_rd       = '0;
      hz.ex_redirect = 1'b0;
      hz.imem_ready  = 1'b1;
      hz.dmem_req    = 1'b0;
      hz.dmem_ready  = 1'b1;
      nRST           = 1'b0;

      // Reset: RUN rules apply, counters and halt cleared.
      #12;
      check("rst_halt_out", halt_out, 0);
      check("rst_stall_cnt", stall_cnt, 0);
      check("rst_flush_cnt", flush_cnt, 0);
      check("rst_pc_en", hz.pc_en, 1);
      check("rst_mem_wb_en", hz.mem_wb_en, 1);
      nRST = 1'b1;
      tick();

      // Load-use on rs: stall fetch and decode, bubble into EX.
      hz.ex_memRead = 1'b1; hz.ex_RegWrite = 1'b1; hz.ex_rd = 5'd8;
      set_instr(5'd8, 5'd3);
      #1;
      check("lu_pc_en", hz.pc_en, 0);
      check("lu_if_id_en", hz.if_id_en, 0);
      check("lu_id_ex_flush", hz.id_ex_flush, 1);
      check("lu_id_ex_en", hz.id_ex_en, 1);
      check("lu_if_id_flush", hz.if_id_flush, 0);
      tick();
      check("lu_stall_cnt", stall_cnt, 1);
      check("lu_flush_cnt", flush_cnt, 0);

      // Redirect overrides the same load-use.
      hz.ex_redirect = 1'b1;
      #1;
      check("rd_pc_en", hz.pc_en, 1);
      check("rd_if_id_en", hz.if_id_en, 1);
      check("rd_if_id_flush", hz.if_id_flush, 1);
      check("rd_id_ex_flush", hz.id_ex_flush, 1);
      tick();
      check("rd_flush_cnt", flush_cnt, 1);
      check("rd_stall_cnt", stall_cnt, 1);

      // Load into r0 never stalls.
      hz.ex_redirect = 1'b0; hz.ex_rd = 5'd0;
      set_instr(5'd0, 5'd0);
      #1;
      check("r0_pc_en", hz.pc_en, 1);
      check("r0_if_id_en", hz.if_id_en, 1);
      check("r0_id_ex_flush", hz.id_ex_flush, 0);
      tick();
      check("r0_stall_cnt", stall_cnt, 1);

      // rt match only counts when the instruction reads rt.
      hz.ex_rd = 5'd9;
      set_instr(5'd1, 5'd9);
      #1;
      check("rt_unused_pc_en", hz.pc_en, 1);
      hz.id_uses_rt = 1'b1;
      #1;
      check("rt_used_pc_en", hz.pc_en, 0);
      check("rt_used_id_ex_flush", hz.id_ex_flush, 1);
      tick();
      check("rt_stall_cnt", stall_cnt, 2);
      hz.ex_memRead = 1'b0; hz.ex_RegWrite = 1'b0; hz.id_uses_rt = 1'b0;

      // Instruction memory not ready: hold PC, bubble into ID.
      hz.imem_ready = 1'b0;
      #1;
      check("im_pc_en", hz.pc_en, 0);
      check("im_if_id_flush", hz.if_id_flush, 1);
      check("im_if_id_en", hz.if_id_en, 1);
      check("im_ex_mem_en", hz.ex_mem_en, 1);
      tick();
      check("im_stall_cnt", stall_cnt, 2);
      hz.imem_ready = 1'b1;

      // Data memory freeze in RUN stops everything and counts a stall.
      hz.dmem_req = 1'b1; hz.dmem_ready = 1'b0;
      #1;
      check("fz_pc_en", hz.pc_en, 0);
      check("fz_mem_wb_en", hz.mem_wb_en, 0);
      check("fz_if_id_flush", hz.if_id_flush, 0);
      tick();
      check("fz_stall_cnt", stall_cnt, 3);
      hz.dmem_req = 1'b0; hz.dmem_ready = 1'b1;

      // Halt accepted in RUN.
      hz.id_halt = 1'b1;
      #1;
      check("hlt_pc_en", hz.pc_en, 0);
      check("hlt_if_id_en", hz.if_id_en, 0);
      check("hlt_id_ex_en", hz.id_ex_en, 1);
      tick();
      hz.id_halt = 1'b0;
      // DRAIN cycle 1 (count 3 -> 2).
      #1;
      check("dr_pc_en", hz.pc_en, 0);
      check("dr_if_id_flush", hz.if_id_flush, 1);
      check("dr_ex_mem_en", hz.ex_mem_en, 1);
      check("dr_halt_out", halt_out, 0);
      tick();
      // DRAIN cycles 2-3: frozen, countdown holds.
      hz.dmem_req = 1'b1; hz.dmem_ready = 1'b0;
      #1;
      check("drfz_mem_wb_en", hz.mem_wb_en, 0);
      check("drfz_if_id_flush", hz.if_id_flush, 0);
      tick();
      tick();
      check("drfz_halt_out", halt_out, 0);
      check("drfz_stall_cnt", stall_cnt, 3);
      hz.dmem_req = 1'b0; hz.dmem_ready = 1'b1;
      // DRAIN cycle 4 (2 -> 1), still draining.
      tick();
      check("dr4_halt_out", halt_out, 0);
      check("dr4_pc_en", hz.pc_en, 0);
      // DRAIN cycle 5 (1 -> HALTED).
      tick();
      check("hd_halt_out", halt_out, 1);
      check("hd_pc_en", hz.pc_en, 0);
      check("hd_id_ex_en", hz.id_ex_en, 0);
      check("hd_mem_wb_en", hz.mem_wb_en, 0);
      check("hd_if_id_flush", hz.if_id_flush, 0);

      // HALTED ignores redirect/freeze: counters frozen, still halted.
      hz.ex_redirect = 1'b1; hz.dmem_req = 1'b1; hz.dmem_ready = 1'b0;
      tick();
      tick();
      check("hd_flush_cnt", flush_cnt, 1);
      check("hd_stall_cnt", stall_cnt, 3);
      check("hd_halt_hold", halt_out, 1);
      hz.ex_redirect = 1'b0; hz.dmem_req = 1'b0; hz.dmem_ready = 1'b1;

      // Asynchronous reset between edges leaves HALTED immediately.
      #2;
      nRST = 1'b0;
      #1;
      check("ar_halt_out", halt_out, 0);
      check("ar_stall_cnt", stall_cnt, 0);
      check("ar_flush_cnt", flush_cnt, 0);
      check("ar_pc_en", hz.pc_en, 1);
      #1;
      nRST = 1'b1;
      tick();
      check("ar_run_halt_out", halt_out, 0);
      check("ar_run_if_id_en", hz.if_id_en, 1);

      // Long freeze: stall counter saturates at all-ones.
      hz.dmem_req = 1'b1; hz.dmem_ready = 1'b0;
      repeat (70000) @(posedge CLK);
      #1;
      check("sat_stall_cnt", stall_cnt, 16'hFFFF);
      check("sat_flush_cnt", flush_cnt, 0);
      check("sat_halt_out", halt_out, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
